instruction_fetch: RTL and testbench



---
 rtl/mips_pkg.sv | 13 +
 rtl/if_id_reg.sv | 60 ++++++
 rtl/instruction_fetch.sv | 143 ++++++++++++++
 tb/tb_instruction_fetch.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: fetch FSM states and fetch-stage constants.
package mips_pkg;

  localparam int unsigned WORD_BYTES       = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StDrop
  } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// Single-entry IF/ID buffer: load from fetch, consume by decode, flush on redirect.
module if_id_reg
  import mips_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  input  logic        consume_i,
  input  logic        flush_i,
  output logic        valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc4_o
);

  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc4_q, pc4_d;

  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    pc4_d   = pc4_q;
    // Flush wins over both a same-cycle consume and load.
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      instr_d = instr_i;
      pc_d    = pc_i;
      pc4_d   = pc_i + 32'(WORD_BYTES);
    end else if (consume_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
      pc4_q   <= 32'(WORD_BYTES);
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
      pc4_q   <= pc4_d;
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;
  assign pc4_o   = pc4_q;

endmodule

// File: rtl/instruction_fetch.sv
// MIPS fetch stage: PC/FSM, single-outstanding imem req/ack, branch redirect.
// Define FETCH_PERF_EN to enable the perf_fetched/perf_dropped counters.
module instruction_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc4,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_dropped
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  tgt_q, tgt_d;
  logic         req_q, req_d;
  logic         ack, load, drop, consume;
  logic [31:0]  target;
  logic         target_lsb_unused;

  assign ack               = imem_ack & req_q;
  assign consume           = if_valid & if_ready;
  assign target            = {branch_target[31:2], 2'b00};
  assign target_lsb_unused = ^branch_target[1:0];

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    tgt_d   = tgt_q;
    req_d   = req_q;
    load    = 1'b0;
    drop    = 1'b0;
    unique case (state_q)
      StIdle: begin
        state_d = StReq;
        if (branch_taken) pc_d = target;
      end
      StReq: begin
        if (ack) begin
          req_d = 1'b0;
          if (branch_taken) begin
            drop = 1'b1;
            pc_d = target;
          end else begin
            load = 1'b1;
            pc_d = pc_q + 32'(WORD_BYTES);
          end
        end else if (req_q) begin
          // Keep req/addr stable; remember where to go once the ack arrives.
          if (branch_taken) begin
            tgt_d   = target;
            state_d = StDrop;
          end
        end else begin
          if (branch_taken) pc_d = target;
          if (!if_valid || if_ready) req_d = 1'b1;
        end
      end
      StDrop: begin
        if (branch_taken) tgt_d = target;
        if (ack) begin
          req_d   = 1'b0;
          drop    = 1'b1;
          pc_d    = branch_taken ? target : tgt_q;
          state_d = StReq;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
      tgt_q   <= RESET_PC;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      req_q   <= req_d;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = pc_q;

  if_id_reg u_if_id_reg (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .load_i    (load),
    .instr_i   (imem_rdata),
    .pc_i      (pc_q),
    .consume_i (consume),
    .flush_i   (branch_taken),
    .valid_o   (if_valid),
    .instr_o   (if_instr),
    .pc_o      (if_pc),
    .pc4_o     (if_pc4)
  );

`ifdef FETCH_PERF_EN
  logic [31:0] fetched_q, fetched_d;
  logic [31:0] dropped_q, dropped_d;

  always_comb begin
    fetched_d = fetched_q + {31'b0, load};
    dropped_d = dropped_q + {31'b0, drop};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetched_q <= '0;
      dropped_q <= '0;
    end else begin
      fetched_q <= fetched_d;
      dropped_q <= dropped_d;
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_dropped = dropped_q;
`else
  logic drop_unused;
  assign drop_unused  = drop;
  assign perf_fetched = '0;
  assign perf_dropped = '0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: scoreboard of loaded instructions vs decode handshakes.
`timescale 1ns/1ps
module tb_instruction_fetch;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_instr, if_pc, if_pc4;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic [31:0] perf_fetched, perf_dropped;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t sb[$];
  int     checks = 0;
  int     errors = 0;
  int     fetched_model = 0;
  int     dropped_model = 0;

  always #5 clk = ~clk;

  instruction_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .if_valid      (if_valid),
    .if_ready      (if_ready),
    .if_instr      (if_instr),
    .if_pc         (if_pc),
    .if_pc4        (if_pc4),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .perf_fetched  (perf_fetched),
    .perf_dropped  (perf_dropped)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h8C00_0000 ^ {a[15:0], ~a[15:0]};
  endfunction

  function automatic logic [31:0] exp_fetched();
`ifdef FETCH_PERF_EN
    return 32'(fetched_model);
`else
    return 32'h0;
`endif
  endfunction

  function automatic logic [31:0] exp_dropped();
`ifdef FETCH_PERF_EN
    return 32'(dropped_model);
`else
    return 32'h0;
`endif
  endfunction

  // One clock: retire any decode handshake against the scoreboard, then sample #1 after the edge.
  task automatic step();
    entry_t e;
    if (branch_taken) begin
      sb.delete();
    end else if (if_valid === 1'b1 && if_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL consume_unexpected: if_pc=%h consumed, scoreboard empty", if_pc);
      end else begin
        e = sb.pop_front();
        if (if_instr !== e.instr || if_pc !== e.pc || if_pc4 !== e.pc + 32'd4) begin
          errors++;
          $display("FAIL consume_data: instr=%h pc=%h pc4=%h, required instr=%h pc=%h pc4=%h",
                   if_instr, if_pc, if_pc4, e.instr, e.pc, e.pc + 32'd4);
        end
      end
    end
    @(posedge clk);
    #1;
    checks++;
    if (if_valid !== (sb.size() != 0)) begin
      errors++;
      $display("FAIL valid_track: if_valid=%b, required %b", if_valid, sb.size() != 0);
    end
  endtask

  task automatic wait_req(input string name, output int waited);
    waited = 0;
    while (imem_req !== 1'b1 && waited < 20) begin
      step();
      waited++;
    end
    checks++;
    if (imem_req !== 1'b1) begin
      errors++;
      $display("FAIL %s_req_timeout: imem_req=%b after %0d cycles, required 1", name, imem_req,
               waited);
    end
  endtask

  task automatic do_ack(input bit drop, input bit br, input logic [31:0] tgt);
    logic [31:0] a;
    a             = imem_addr;
    imem_ack      = 1'b1;
    imem_rdata    = mem_word(a);
    branch_taken  = br;
    branch_target = tgt;
    if (drop || br) begin
      dropped_model++;
    end else begin
      sb.push_back('{pc: a, instr: mem_word(a)});
      fetched_model++;
    end
    step();
    imem_ack     = 1'b0;
    imem_rdata   = '0;
    branch_taken = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks += 7;
    if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: %b, required 0", imem_req); end
    if (imem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr: %h, required 0", imem_addr); end
    if (if_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: %b, required 0", if_valid); end
    if (if_instr !== 32'h0) begin errors++; $display("FAIL rst_instr: %h, required 0", if_instr); end
    if (if_pc !== 32'h0) begin errors++; $display("FAIL rst_pc: %h, required 0", if_pc); end
    if (if_pc4 !== 32'h4) begin errors++; $display("FAIL rst_pc4: %h, required 4", if_pc4); end
    if (perf_fetched !== 32'h0 || perf_dropped !== 32'h0) begin
      errors++;
      $display("FAIL rst_perf: %h/%h, required 0/0", perf_fetched, perf_dropped);
    end
    rst_n = 1'b1;
    step();
    checks++;
    if (imem_req !== 1'b0) begin errors++; $display("FAIL edge0_req: %b, required 0", imem_req); end
    step();
    checks += 2;
    if (imem_req !== 1'b1) begin errors++; $display("FAIL edge1_req: %b, required 1", imem_req); end
    if (imem_addr !== 32'h0) begin errors++; $display("FAIL edge1_addr: %h, required 0", imem_addr); end
  endtask

  task automatic test_sequence();
    int w;
    if_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_req("seq", w);
      checks++;
      if (imem_addr !== 32'(4 * i)) begin
        errors++;
        $display("FAIL seq_addr: %h, required %h", imem_addr, 32'(4 * i));
      end
      if (i > 0) begin
        checks++;
        if (w != 1) begin errors++; $display("FAIL seq_gap: %0d cycles, required 1", w); end
      end
      do_ack(1'b0, 1'b0, 32'h0);
    end
    step();
    checks++;
    if (perf_fetched !== exp_fetched()) begin
      errors++;
      $display("FAIL seq_perf_fetched: %0d, required %0d", perf_fetched, exp_fetched());
    end
  endtask

  task automatic test_stall();
    int w;
    wait_req("stall", w);
    if_ready = 1'b0;
    do_ack(1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      step();
      checks += 2;
      if (if_instr !== mem_word(32'h10)) begin
        errors++;
        $display("FAIL stall_instr: %h, required %h", if_instr, mem_word(32'h10));
      end
      if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_req: %b, required 0", imem_req); end
    end
    if_ready = 1'b1;
    step();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h14) begin
      errors++;
      $display("FAIL stall_resume: req=%b addr=%h, required 1/00000014", imem_req, imem_addr);
    end
  endtask

  task automatic test_branch_idle();
    int w;
    if_ready = 1'b0;
    do_ack(1'b0, 1'b0, 32'h0);
    branch_taken  = 1'b1;
    branch_target = 32'h40;
    step();
    branch_taken = 1'b0;
    checks++;
    if (if_valid !== 1'b0) begin errors++; $display("FAIL bidle_flush: %b, required 0", if_valid); end
    if_ready = 1'b1;
    wait_req("bidle", w);
    checks++;
    if (imem_addr !== 32'h40) begin errors++; $display("FAIL bidle_addr: %h, required 40", imem_addr); end
  endtask

  task automatic test_drop_outstanding();
    int w;
    branch_taken  = 1'b1;
    branch_target = 32'h80;
    step();
    branch_taken = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin
        errors++;
        $display("FAIL drop_hold: req=%b addr=%h, required 1/00000040", imem_req, imem_addr);
      end
    end
    do_ack(1'b1, 1'b0, 32'h0);
    wait_req("drop", w);
    checks += 2;
    if (imem_addr !== 32'h80) begin errors++; $display("FAIL drop_addr: %h, required 80", imem_addr); end
    if (perf_dropped !== exp_dropped()) begin
      errors++;
      $display("FAIL drop_perf: %0d, required %0d", perf_dropped, exp_dropped());
    end
    do_ack(1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_branch_on_ack();
    int w;
    wait_req("back", w);
    do_ack(1'b1, 1'b1, 32'h103);
    wait_req("back2", w);
    checks += 2;
    if (imem_addr !== 32'h100) begin errors++; $display("FAIL back_addr: %h, required 100", imem_addr); end
    if (perf_dropped !== exp_dropped()) begin
      errors++;
      $display("FAIL back_perf: %0d, required %0d", perf_dropped, exp_dropped());
    end
  endtask

  task automatic test_reset_mid();
    int w;
    rst_n = 1'b0;
    #1;
    sb.delete();
    fetched_model = 0;
    dropped_model = 0;
    checks += 3;
    if (imem_req !== 1'b0 || imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL mrst_req: req=%b addr=%h, required 0/00000000", imem_req, imem_addr);
    end
    if (if_valid !== 1'b0 || if_pc !== 32'h0 || if_pc4 !== 32'h4 || if_instr !== 32'h0) begin
      errors++;
      $display("FAIL mrst_buf: v=%b pc=%h pc4=%h instr=%h, required 0/0/4/0", if_valid, if_pc,
               if_pc4, if_instr);
    end
    if (perf_fetched !== 32'h0 || perf_dropped !== 32'h0) begin
      errors++;
      $display("FAIL mrst_perf: %h/%h, required 0/0", perf_fetched, perf_dropped);
    end
    step();
    rst_n      = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    step();
    step();
    imem_ack   = 1'b0;
    imem_rdata = '0;
    checks += 2;
    if (perf_fetched !== 32'h0) begin errors++; $display("FAIL stale_perf: %h, required 0", perf_fetched); end
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL stale_req: req=%b addr=%h, required 1/00000000", imem_req, imem_addr);
    end
    do_ack(1'b0, 1'b0, 32'h0);
    step();
    wait_req("mrst", w);
    checks += 2;
    if (imem_addr !== 32'h4) begin errors++; $display("FAIL mrst_addr: %h, required 4", imem_addr); end
    if (perf_fetched !== exp_fetched()) begin
      errors++;
      $display("FAIL mrst_perf_fetched: %0d, required %0d", perf_fetched, exp_fetched());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_sequence();
    test_stall();
    test_branch_idle();
    test_drop_outstanding();
    test_branch_on_ack();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
